alu_cmd_sequencer: RTL and testbench
====================================

ALU_CMD_SEQUENCER -- requirements
Module: alu_cmd_sequencer

Interface
REQ-001 Parameter DEPTH, default 4, meaning operation FIFO depth in entries, power of two, at least 2.
REQ-002 Parameter HOLD, default 2, meaning cycles each operation is held on the ALU command port.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  upstream offers an operation.
REQ-006 in_ready  output  1  sequencer accepts the operation this cycle.
REQ-007 in_clear  input  1  offered entry is an accumulator-clear, not an arithmetic operation.
REQ-008 in_cmd  input  5  ALU opcode; ignored when in_clear=1.
REQ-009 in_a, in_b  input  16 each  operands; ignored when in_clear=1.
REQ-010 alu_cmd  output  5  drives the ALU cmd input.
REQ-011 alu_a, alu_b  output  16 each  drive the ALU A and B inputs.
REQ-012 alu_noop  output  1  drives the ALU noOp input.
REQ-013 alu_rst  output  1  drives the ALU rst input.
REQ-014 done  output  1  one-cycle pulse: the ALU accumulator holds this entry's result.
REQ-015 busy  output  1  high when state is not IDLE or the FIFO is non-empty.
REQ-016 count  output  clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-017 A push occurs when in_valid and in_ready are both 1; the entry stored is {clear, cmd, a, b}.
REQ-018 in_ready SHALL equal (count < DEPTH), registered-state-based only, with no combinational path from in_valid.
REQ-019 When full, a pop and a push offer in the same cycle: the push is refused because in_ready=0.
REQ-020 When not full, a simultaneous push and pop leaves count unchanged.
REQ-021 FIFO pointers wrap modulo DEPTH.
REQ-022 States are IDLE, ISSUE, CLEAR and COMPLETE.
REQ-023 IDLE: alu_noop=1, alu_rst=0. On a non-empty FIFO, pop the head:
  - arithmetic entry -> ISSUE, hold counter=0;
  - clear entry -> CLEAR.
REQ-024 ISSUE: alu_noop=0, alu_rst=0; alu_cmd/alu_a/alu_b driven from the popped entry register, stable for exactly HOLD cycles; then -> COMPLETE.
REQ-025 ISSUE rationale: cycle 1 loads the ALU operand registers; cycle 2 writes the accumulator with the correct result.
REQ-026 CLEAR: alu_rst=1, alu_noop=0, alu_cmd=0, alu_a=0, alu_b=0 for exactly 1 cycle; then -> COMPLETE.
REQ-027 COMPLETE: done=1, alu_noop=1, alu_rst=0 for 1 cycle; then -> IDLE.
REQ-028 done SHALL be 0 in every state except COMPLETE.
REQ-029 The FIFO may be pushed during any state; only IDLE pops.
REQ-030 Latency, empty FIFO: push in cycle N -> IDLE pop at N+1; ISSUE at N+2..N+1+HOLD; done at N+2+HOLD.
REQ-031 Back-to-back throughput is one operation per HOLD+2 cycles.
REQ-032 Opcode values pass through unmodified; no opcode validation is performed.

Reset
REQ-033 While rst=1 at a clock edge, the block SHALL:
  - set state to IDLE and empty the FIFO (count=0, pointers 0);
  - drive alu_noop=1, alu_rst=0, alu_cmd=0, alu_a=0, alu_b=0, done=0;
  - drive in_ready=1, busy=0.
REQ-034 Reset mid-ISSUE or mid-CLEAR abandons the operation without a done pulse; FIFO contents are discarded.
REQ-035 The block SHALL NOT drive alu_rst as a consequence of its own rst.

Structure
REQ-036 A shared package SHALL hold:
  - the state enumeration;
  - the FIFO entry struct {clear, cmd[4:0], a[15:0], b[15:0]};
  - constants OP_W=5 and DATA_W=16.
REQ-037 The FIFO SHALL be a sub-module named op_fifo (parameter DEPTH, synchronous reset, push/pop/full/empty/count); the FSM stays in the top module.

Verification
REQ-038 Single add: push cmd=5'b00001, a=17, b=15 -> per REQ-030 timing, alu_noop low for exactly 2 cycles, done pulses once, ALU accumulator reads 32.
REQ-039 Clear then multiply: push clear, then cmd=00011, a=300, b=200:
  - alu_rst high for exactly 1 cycle;
  - two done pulses;
  - final accumulator reads 60000.
REQ-040 Full FIFO: push 5 entries with DEPTH=4 while the sequencer is stalled in ISSUE -> count=4, in_ready=0, fifth entry not accepted until the first pop; all entries later issued in order.
REQ-041 Reset mid-ISSUE: rst=1 on the 1st ISSUE cycle with 3 entries queued -> next cycle count=0, alu_noop=1, no done pulse.
REQ-042 Streaming: in_valid held high with 8 entries -> done pulses spaced exactly HOLD+2=4 cycles apart, no entry lost or duplicated, count never exceeds DEPTH.

Source files
------------

// File: rtl/alu_cmd_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// alu_cmd_sequencer_pkg : shared types and widths for the ALU command sequencer
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package alu_cmd_sequencer_pkg;

  localparam int OP_W   = 5;
  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    CLEAR    = 2'd2,
    COMPLETE = 2'd3
  } state_t;

  typedef struct packed {
    logic              clear;
    logic [OP_W-1:0]   cmd;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } op_entry_t;

endpackage

`default_nettype wire

// File: rtl/op_fifo.sv
// ---------------------------------------------------------------------------
// op_fifo : power-of-two operation FIFO with occupancy counter and full/empty
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module op_fifo
  import alu_cmd_sequencer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  op_entry_t              push_data,
  input  logic                   pop,
  output op_entry_t              head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  op_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/alu_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// alu_cmd_sequencer : queues ALU operations and replays each on the ALU port
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module alu_cmd_sequencer
  import alu_cmd_sequencer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int HOLD  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_clear,
  input  logic [OP_W-1:0]        in_cmd,
  input  logic [DATA_W-1:0]      in_a,
  input  logic [DATA_W-1:0]      in_b,
  output logic [OP_W-1:0]        alu_cmd,
  output logic [DATA_W-1:0]      alu_a,
  output logic [DATA_W-1:0]      alu_b,
  output logic                   alu_noop,
  output logic                   alu_rst,
  output logic                   done,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] count
);

  localparam int HOLD_W = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD - 1);

  state_t            state;
  state_t            state_nxt;
  logic [HOLD_W-1:0] hold_cnt;
  logic [OP_W-1:0]   cur_cmd;
  logic [DATA_W-1:0] cur_a;
  logic [DATA_W-1:0] cur_b;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  op_entry_t         fifo_head;
  op_entry_t         push_entry;

  assign push_entry = '{clear: in_clear, cmd: in_cmd, a: in_a, b: in_b};
  assign in_ready   = !fifo_full;
  assign busy       = (state != IDLE) || !fifo_empty;

  op_fifo #(
    .DEPTH (DEPTH)
  ) u_op_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (in_valid),
    .push_data (push_entry),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      hold_cnt <= '0;
      cur_cmd  <= '0;
      cur_a    <= '0;
      cur_b    <= '0;
    end else begin
      state <= state_nxt;
      if (fifo_pop) begin
        cur_cmd  <= fifo_head.cmd;
        cur_a    <= fifo_head.a;
        cur_b    <= fifo_head.b;
        hold_cnt <= '0;
      end else if (state == ISSUE) begin
        hold_cnt <= hold_cnt + HOLD_W'(1);
      end
    end
  end

  // Operands are driven only in ISSUE; every other state presents zeros.
  always_comb begin
    state_nxt = state;
    fifo_pop  = 1'b0;
    alu_noop  = 1'b1;
    alu_rst   = 1'b0;
    alu_cmd   = '0;
    alu_a     = '0;
    alu_b     = '0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          state_nxt = fifo_head.clear ? CLEAR : ISSUE;
        end
      end
      ISSUE: begin
        alu_noop = 1'b0;
        alu_cmd  = cur_cmd;
        alu_a    = cur_a;
        alu_b    = cur_b;
        if (hold_cnt == HOLD_LAST) begin
          state_nxt = COMPLETE;
        end
      end
      CLEAR: begin
        alu_noop  = 1'b0;
        alu_rst   = 1'b1;
        state_nxt = COMPLETE;
      end
      COMPLETE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_cmd_sequencer : scoreboard bench with a behavioural ALU and queue model
// Revision 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_alu_cmd_sequencer;
  import alu_cmd_sequencer_pkg::*;

  localparam int DEPTH   = 4;
  localparam int HOLD    = 2;
  localparam int CW      = $clog2(DEPTH) + 1;
  localparam int TIMEOUT = 200;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_clear = 1'b0;
  logic [OP_W-1:0]   in_cmd = '0;
  logic [DATA_W-1:0] in_a = '0;
  logic [DATA_W-1:0] in_b = '0;
  logic              in_ready;
  logic [OP_W-1:0]   alu_cmd;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic              alu_noop;
  logic              alu_rst;
  logic              done;
  logic              busy;
  logic [CW-1:0]     count;

  always #5 clk = ~clk;

  alu_cmd_sequencer #(
    .DEPTH (DEPTH),
    .HOLD  (HOLD)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_clear (in_clear),
    .in_cmd   (in_cmd),
    .in_a     (in_a),
    .in_b     (in_b),
    .alu_cmd  (alu_cmd),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_noop (alu_noop),
    .alu_rst  (alu_rst),
    .done     (done),
    .busy     (busy),
    .count    (count)
  );

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural ALU: operands register on the first noOp-low cycle, accumulator on the next.
  function automatic logic [15:0] alu_fn(input logic [4:0] c, input logic [15:0] a, input logic [15:0] b);
    case (c)
      5'd1:    return a + b;
      5'd2:    return a - b;
      5'd3:    return a * b;
      5'd4:    return a & b;
      5'd5:    return a | b;
      5'd6:    return a ^ b;
      default: return a;
    endcase
  endfunction

  logic [4:0]  r_c = '0;
  logic [15:0] r_a = '0;
  logic [15:0] r_b = '0;
  logic [15:0] acc = '0;

  always @(posedge clk) begin
    if (alu_rst) begin
      acc <= '0;
    end else if (!alu_noop) begin
      r_c <= alu_cmd;
      r_a <= alu_a;
      r_b <= alu_b;
      acc <= alu_fn(r_c, r_a, r_b);
    end
  end

  typedef struct {
    op_entry_t   ent;
    logic [15:0] res;
    int          push_cyc;
    bit          lat;
  } exp_t;

  exp_t      sbq[$];
  int        done_cycles[$];
  exp_t      m_e;
  exp_t      m_new;
  op_entry_t cap = '0;
  int        n_push = 0;
  int        n_start = 0;
  int        n_op = 0;
  int        occ;
  int        rst_hi = 0;
  int        max_cnt = 0;
  logic      prev_noop = 1'b1;
  logic      prev_done = 1'b0;
  bit        mark_latency = 0;
  bit        saw_full = 0;

  // Monitor: occupancy model, ALU-port observation and scoreboard pops.
  always @(negedge clk) begin
    if (!alu_noop) begin
      if (prev_noop) begin
        n_start++;
        cap  = {alu_rst, alu_cmd, alu_a, alu_b};
        n_op = 1;
      end else begin
        n_op++;
        check("op_stable", 64'({alu_rst, alu_cmd, alu_a, alu_b}), 64'(cap));
      end
    end
    if (alu_rst) rst_hi++;
    if (int'(count) > max_cnt) max_cnt = int'(count);
    occ = n_push - n_start;
    check("count", 64'(count), 64'(occ));
    check("in_ready", 64'(in_ready), 64'(occ < DEPTH));
    check("busy", 64'(busy), 64'(occ != 0 || !alu_noop || done));
    if (done) begin
      done_cycles.push_back(cyc);
      check("done_width", 64'(prev_done), 64'(0));
      if (sbq.size() == 0) begin
        check("done_unexpected", 64'(done), 64'(0));
      end else begin
        m_e = sbq.pop_front();
        check("op_fields", 64'(cap), 64'(m_e.ent));
        check("op_cycles", 64'(n_op), 64'(m_e.ent.clear ? 1 : HOLD));
        check("accumulator", 64'(acc), 64'(m_e.res));
        if (m_e.lat) check("latency", 64'(cyc - m_e.push_cyc), 64'(HOLD + 2));
      end
      n_op = 0;
    end
    if (in_valid && in_ready && !rst) begin
      m_new.ent = '0;
      m_new.res = '0;
      if (in_clear) begin
        m_new.ent.clear = 1'b1;
      end else begin
        m_new.ent.cmd = in_cmd;
        m_new.ent.a   = in_a;
        m_new.ent.b   = in_b;
        m_new.res     = alu_fn(in_cmd, in_a, in_b);
      end
      m_new.push_cyc = cyc;
      m_new.lat      = mark_latency;
      sbq.push_back(m_new);
      n_push++;
    end
    if (rst) begin
      sbq.delete();
      n_push  = 0;
      n_start = 0;
      n_op    = 0;
    end
    prev_noop = rst ? 1'b1 : alu_noop;
    prev_done = done;
  end

  // Drivers enter and leave at posedge+1.
  task automatic send(input logic clr, input logic [4:0] c, input logic [15:0] a, input logic [15:0] b);
    int t = 0;
    in_valid = 1'b1;
    in_clear = clr;
    in_cmd   = c;
    in_a     = a;
    in_b     = b;
    @(negedge clk);
    while (in_ready !== 1'b1 && t < TIMEOUT) begin
      check("full_count", 64'(count), 64'(DEPTH));
      saw_full = 1;
      @(negedge clk);
      t++;
    end
    if (in_ready !== 1'b1) check("send_timeout", 64'(in_ready), 64'(1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic rand_arith();
    in_valid = 1'b1;
    in_clear = 1'b0;
    in_cmd   = 5'($urandom_range(0, 31));
    in_a     = 16'($urandom);
    in_b     = 16'($urandom);
  endtask

  task automatic wait_idle();
    int t = 0;
    @(negedge clk);
    while (busy !== 1'b0 && t < TIMEOUT) begin
      @(negedge clk);
      t++;
    end
    if (busy !== 1'b0) check("idle_timeout", 64'(busy), 64'(0));
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_count"}, 64'(count), 64'(0));
    check({tag, "_in_ready"}, 64'(in_ready), 64'(1));
    check({tag, "_busy"}, 64'(busy), 64'(0));
    check({tag, "_noop"}, 64'(alu_noop), 64'(1));
    check({tag, "_alu_rst"}, 64'(alu_rst), 64'(0));
    check({tag, "_done"}, 64'(done), 64'(0));
    check({tag, "_operands"}, 64'({alu_cmd, alu_a, alu_b}), 64'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int rbase;
    int gap;
    bit found;
    logic rdy;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset_state("reset");
    @(posedge clk);
    #1;

    // Single add with empty-FIFO latency.
    base = done_cycles.size();
    mark_latency = 1;
    send(1'b0, 5'b00001, 16'd17, 16'd15);
    mark_latency = 0;
    wait_idle();
    check("add_acc", 64'(acc), 64'(32));
    check("add_dones", 64'(done_cycles.size() - base), 64'(1));

    // Clear followed by multiply; clear carries junk operands that must be ignored.
    base  = done_cycles.size();
    rbase = rst_hi;
    send(1'b1, 5'd7, 16'hBEEF, 16'h1234);
    send(1'b0, 5'b00011, 16'd300, 16'd200);
    wait_idle();
    check("mul_acc", 64'(acc), 64'(60000));
    check("clear_rst_cycles", 64'(rst_hi - rbase), 64'(1));
    check("clear_mul_dones", 64'(done_cycles.size() - base), 64'(2));

    // Fill the FIFO behind an issuing operation.
    saw_full = 0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      send(1'b0, 5'($urandom_range(0, 31)), 16'($urandom), 16'($urandom));
    end
    check("saw_full", 64'(saw_full), 64'(1));
    wait_idle();

    // Reset on the first ISSUE cycle with the FIFO backed up.
    found = 0;
    rand_arith();
    for (int t = 0; t < 100 && !found; t++) begin
      @(negedge clk);
      if (alu_noop && !done && count == FULL_CNT) begin
        found = 1;
      end else begin
        rdy = in_ready;
        @(posedge clk);
        #1;
        if (rdy) rand_arith();
      end
    end
    check("rst_setup", 64'(found), 64'(1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    check("rst_issue_count", 64'(count), 64'(DEPTH - 1));
    check("rst_issue_noop", 64'(alu_noop), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset_state("midrst");
    base = done_cycles.size();
    repeat (8) @(negedge clk);
    check("midrst_no_done", 64'(done_cycles.size() - base), 64'(0));
    @(posedge clk);
    #1;

    // Streaming: in_valid held high across eight operations.
    base    = done_cycles.size();
    max_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      send(1'b0, 5'($urandom_range(0, 31)), 16'($urandom), 16'($urandom));
    end
    wait_idle();
    check("stream_dones", 64'(done_cycles.size() - base), 64'(8));
    for (int i = base + 1; i < done_cycles.size(); i++) begin
      check("stream_spacing", 64'(done_cycles[i] - done_cycles[i-1]), 64'(HOLD + 2));
    end
    check("stream_max_count", 64'(max_cnt <= DEPTH), 64'(1));

    // Random mix of clears and arithmetic with random gaps.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        send(1'b1, 5'($urandom_range(0, 31)), 16'($urandom), 16'($urandom));
      end else begin
        send(1'b0, 5'($urandom_range(0, 31)), 16'($urandom), 16'($urandom));
      end
      gap = $urandom_range(0, 3);
      repeat (gap) begin
        @(posedge clk);
        #1;
      end
    end
    wait_idle();
    check("scoreboard_drained", 64'(sbq.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

`default_nettype wire
